// File: rtl/mod_ctrl_if.sv
// Request/response, operand and datapath-control signals of the modulo controller.
// slave is the controller view; master is the requester/datapath side.
interface mod_ctrl_if;
  logic        req0;
  logic        req1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic [31:0] dp_A;
  logic [31:0] dp_B;
  logic        dp_load;
  logic        dp_subtract;
  logic        dp_subtract_ack;
  logic [31:0] dp_result;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_err;
  logic        busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, dp_subtract_ack, dp_result,
    output dp_A, dp_B, dp_load, dp_subtract, rsp_valid, rsp_id, rsp_result, rsp_err, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, dp_subtract_ack, dp_result,
    input  dp_A, dp_B, dp_load, dp_subtract, rsp_valid, rsp_id, rsp_result, rsp_err, busy
  );
endinterface

// File: rtl/mod_ctrl.sv
// Round-robin two-requester controller sequencing a subtract-based A mod B datapath.
// Latency k+6 cycles for A=k*B+r; requesters hold req until their one-cycle rsp_valid.
module mod_ctrl #(
  parameter int unsigned MAX_ITER = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  mod_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_ITER + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_ITER);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_RES, RESP} state_t;

  state_t        state_q, state_d;
  logic          cur_id_q, cur_id_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dp_a_q, dp_a_d;
  logic [31:0]   dp_b_q, dp_b_d;
  logic          dp_load_q, dp_load_d;
  logic          dp_sub_q, dp_sub_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;

  logic          gnt_id;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;

  // With both requests pending, the one not served last wins.
  always_comb begin
    gnt_id = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    sel_a  = gnt_id ? bus.a1 : bus.a0;
    sel_b  = gnt_id ? bus.b1 : bus.b0;
  end

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          cur_id_d = gnt_id;
          dp_a_d   = sel_a;
          dp_b_d   = sel_b;
          if (sel_b == 32'd0) begin
            state_d      = RESP;
            rsp_result_d = 32'd0;
            rsp_err_d    = 2'b01;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus.dp_subtract_ack) begin
          state_d = WAIT_RES;
        end else if (cnt_q + CW'(1) == MAX_C) begin
          state_d      = RESP;
          rsp_result_d = 32'd0;
          rsp_err_d    = 2'b10;
        end
      end
      WAIT_RES: begin
        rsp_result_d = bus.dp_result;
        rsp_err_d    = 2'b00;
        state_d      = RESP;
      end
      RESP: begin
        last_d  = cur_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered alongside the next state so they align with it.
    dp_load_d   = (state_d == LOAD);
    dp_sub_d    = (state_d == RUN);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
    rsp_id_d    = (state_d == RESP) ? cur_id_d : rsp_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_id_q     <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      dp_a_q       <= 32'd0;
      dp_b_q       <= 32'd0;
      dp_load_q    <= 1'b0;
      dp_sub_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_err_q    <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_load_q    <= dp_load_d;
      dp_sub_q     <= dp_sub_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dp_A        = dp_a_q;
  assign bus.dp_B        = dp_b_q;
  assign bus.dp_load     = dp_load_q;
  assign bus.dp_subtract = dp_sub_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = busy_q;

endmodule
